// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the RAM bus initiator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_bus_pkg;

  localparam int BUS_AW     = 16;  // byte address width
  localparam int BUS_DW     = 16;  // word width
  localparam int WORD_BYTES = 2;   // bytes per word, big-endian {M[a], M[a+1]}

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WSET,
    ST_WSTB,
    ST_WHLD,
    ST_RESP
  } state_e;

  // Encoding matches the arbiter request/grant bit index.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin tie arbiter: a lone request wins, a tie goes to the port not granted last.
// Latency: grant is combinational from req; the last-grant flop updates on the edge where advance=1.
// Backpressure: none; the caller only asserts advance when it actually takes the grant.
// Ports: clk, rst_n, req[1:0] (bit0=fetch, bit1=data), advance, grant[1:0] one-hot (0 when no req).
module mem_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 = port 1 (data) was granted last. Reset to fetch so the first tie goes to data.
  logic last_q, last_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (advance && (|req)) begin
      last_d = grant[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// Initiator for a combinational byte-addressed RAM: arbitrates fetch and load/store word requests
// and sequences glitch-free read/write cycles. Latency: ack at +1 (illegal), +RD_WAIT+1 (read), +4 (write).
// Backpressure: req/ack handshake; a requester holds req until its one-cycle ack, others wait in IDLE.
// Ports: clk, rst_n; fetch if_req/if_addr -> if_ack/if_rdata/if_err; data d_req/d_we/d_addr/d_wdata ->
//   d_ack/d_rdata/d_err; RAM mem_r_nWb/mem_addr/mem_wdata (all flops) and mem_rdata; busy = not IDLE.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int AW        = BUS_AW,
  parameter int DW        = BUS_DW,
  parameter int MEM_BYTES = 128,
  parameter int RD_WAIT   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_r_nWb,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_e        state_q, state_d;
  port_e         port_q, port_d;
  logic          err_q, err_d;
  logic [2:0]    wait_q, wait_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_r_nwb_q, mem_r_nwb_d;
  logic          if_ack_q, if_ack_d, d_ack_q, d_ack_d;
  logic          if_err_q, if_err_d, d_err_q, d_err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  logic [1:0]    arb_gnt;
  logic          arb_adv;
  logic          sel_d;
  logic [AW-1:0] sel_addr;
  logic          sel_legal;

  mem_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({d_req, if_req}),
    .advance (arb_adv),
    .grant   (arb_gnt)
  );

  // Legal word: even address with the second byte still inside the RAM.
  assign sel_d     = arb_gnt[1];
  assign sel_addr  = sel_d ? d_addr : if_addr;
  assign sel_legal = !sel_addr[0] && ((int'(sel_addr) + WORD_BYTES - 1) < MEM_BYTES);

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    err_d       = err_q;
    wait_d      = wait_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    arb_adv     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          // The store/load choice is carried by the next state; address and
          // write data are latched straight into the RAM-facing registers.
          arb_adv = 1'b1;
          port_d  = sel_d ? PORT_D : PORT_IF;
          err_d   = !sel_legal;
          wait_d  = 3'd0;
          if (!sel_legal) begin
            // No RAM cycle: mem_addr keeps its old value, rdata reads as zero.
            state_d = ST_RESP;
            if (sel_d) d_rdata_d  = '0;
            else       if_rdata_d = '0;
          end else if (sel_d && d_we) begin
            mem_addr_d  = sel_addr;
            mem_wdata_d = d_wdata;
            state_d     = ST_WSET;
          end else begin
            mem_addr_d = sel_addr;
            state_d    = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (wait_q == 3'(RD_WAIT - 1)) begin
          state_d = ST_RESP;
          if (port_q == PORT_D) d_rdata_d  = mem_rdata;
          else                  if_rdata_d = mem_rdata;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      ST_WSET: state_d = ST_WSTB;
      ST_WSTB: state_d = ST_WHLD;
      ST_WHLD: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered decodes of the next state, so they change
    // cleanly on clock edges and the write strobe never glitches.
    mem_r_nwb_d = (state_d != ST_WSTB);
    if_ack_d    = (state_d == ST_RESP) && (port_d == PORT_IF);
    d_ack_d     = (state_d == ST_RESP) && (port_d == PORT_D);
    if_err_d    = if_ack_d && err_d;
    d_err_d     = d_ack_d && err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_IF;
      err_q       <= 1'b0;
      wait_q      <= 3'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_r_nwb_q <= 1'b1;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_r_nwb_q <= mem_r_nwb_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_err_q    <= if_err_d;
      d_err_q     <= d_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_r_nWb = mem_r_nwb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_err    = if_err_q;
  assign d_err     = d_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomized scoreboard bench for mem_bus_master against a word-level memory model.
// Latency: expected ack cycles derived from the request sequence.
// Backpressure: requests held until acked; ties exercise the round-robin arbiter.
module tb_mem_bus_master;

  localparam int MEMB = 128;
  localparam int RDW  = 1;

  logic        clk, rst_n;
  logic        if_req, if_ack, if_err;
  logic [15:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        mem_r_nWb, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  mem_bus_master #(.AW(16), .DW(16), .MEM_BYTES(MEMB), .RD_WAIT(RDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_r_nWb(mem_r_nWb), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Combinational RAM device; it stores while r_nWb is low.
  logic [7:0] ram [0:MEMB-1];
  logic [7:0] ref_mem [0:MEMB-1];

  always_comb begin
    mem_rdata = 16'h0000;
    if (int'(mem_addr) + 1 < MEMB) mem_rdata = {ram[int'(mem_addr)], ram[int'(mem_addr) + 1]};
  end

  always @(posedge clk) begin
    if (!mem_r_nWb && (int'(mem_addr) + 1 < MEMB)) begin
      ram[int'(mem_addr)]     <= mem_wdata[15:8];
      ram[int'(mem_addr) + 1] <= mem_wdata[7:0];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // Scoreboard entries, pushed by the stimulus side in expected ack order.
  typedef struct {
    bit          is_d;
    bit          err;
    bit          chk_rdata;
    logic [15:0] rdata;
    int          ack_cyc;
    int          lows;
  } exp_t;
  exp_t exp_q[$];

  bit last_is_d = 1'b0;  // reference model: last granted port

  function automatic bit legal_f(input logic [15:0] a);
    return (a % 2 == 0) && (int'(a) + 1 < MEMB);
  endfunction

  // Present requests in an IDLE cycle, predict the outcome, wait for the acks.
  task automatic issue(input bit use_if, input logic [15:0] ia,
                       input bit use_d, input bit dwe, input logic [15:0] da, input logic [15:0] dwd);
    int  t, n;
    bit  ord [2];
    bit  pend_if, pend_d;
    @(negedge clk);
    t = cyc;
    if_req = use_if; if_addr = ia;
    d_req = use_d; d_we = dwe; d_addr = da; d_wdata = dwd;
    n = 0;
    if (use_if && use_d) begin
      ord[0] = !last_is_d; ord[1] = last_is_d; n = 2;
    end else if (use_if || use_d) begin
      ord[0] = use_d; n = 1;
    end
    for (int k = 0; k < n; k++) begin
      exp_t        e;
      logic [15:0] a;
      int          lat;
      e.is_d = ord[k];
      a = e.is_d ? da : ia;
      e.err = !legal_f(a);
      e.lows = 0; e.chk_rdata = 1'b1; e.rdata = 16'h0000;
      if (e.err) begin
        lat = 1;
      end else if (e.is_d && dwe) begin
        lat = 4; e.lows = 1; e.chk_rdata = 1'b0;
        ref_mem[int'(a)] = dwd[15:8]; ref_mem[int'(a) + 1] = dwd[7:0];
      end else begin
        lat = RDW + 1;
        e.rdata = {ref_mem[int'(a)], ref_mem[int'(a) + 1]};
      end
      e.ack_cyc = t + lat;
      t = e.ack_cyc + 1;
      last_is_d = e.is_d;
      exp_q.push_back(e);
    end
    pend_if = use_if; pend_d = use_d;
    for (int w = 0; w < 40 && (pend_if || pend_d); w++) begin
      @(negedge clk);
      if (pend_if && if_ack) begin if_req = 1'b0; pend_if = 1'b0; end
      if (pend_d && d_ack)   begin d_req = 1'b0; pend_d = 1'b0; end
    end
    if (pend_if || pend_d) begin
      checks++; failures++;
      $display("FAIL ack_timeout pending_if=%0d pending_d=%0d", pend_if, pend_d);
      if_req = 1'b0; d_req = 1'b0;
      exp_q.delete();
    end
  endtask

  // Monitor: bus protocol checks and scoreboard comparison on every ack.
  initial begin
    bit          prev_rnwb;
    logic [15:0] prev_addr, prev_wdata;
    int          lows_since;
    prev_rnwb = 1'b1; prev_addr = 16'h0; prev_wdata = 16'h0; lows_since = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lows_since = 0;
      end else begin
        if (!mem_r_nWb) begin
          lows_since++;
          chk("strobe_single_cycle", {31'd0, prev_rnwb}, 32'd1);
          chk("addr_setup", {mem_addr, mem_wdata}, {prev_addr, prev_wdata});
        end else if (!prev_rnwb) begin
          chk("addr_hold", {mem_addr, mem_wdata}, {prev_addr, prev_wdata});
        end
        if (if_ack || d_ack) begin
          if (if_ack && d_ack) begin
            checks++; failures++;
            $display("FAIL dual_ack actual=both required=one");
          end else if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_ack if_ack=%0d d_ack=%0d", if_ack, d_ack);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack_port", {31'd0, d_ack}, {31'd0, e.is_d});
            chk("ack_cycle", cyc, e.ack_cyc);
            chk("err", {31'd0, (e.is_d ? d_err : if_err)}, {31'd0, e.err});
            chk("other_err_zero", {31'd0, (e.is_d ? if_err : d_err)}, 32'd0);
            if (e.chk_rdata) chk("rdata", {16'd0, (e.is_d ? d_rdata : if_rdata)}, {16'd0, e.rdata});
            chk("strobe_count", lows_since, e.lows);
          end
          lows_since = 0;
        end
      end
      prev_rnwb = mem_r_nWb; prev_addr = mem_addr; prev_wdata = mem_wdata;
    end
  end

  initial begin
    bool_init();
  end

  task automatic bool_init();
    rst_n = 1'b1;
    if_req = 1'b0; if_addr = 16'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    for (int i = 0; i < MEMB; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[0] = 8'h12; ram[1] = 8'h01; ref_mem[0] = 8'h12; ref_mem[1] = 8'h01;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_r_nWb", {31'd0, mem_r_nWb}, 32'd1);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_acks_errs", {28'd0, if_ack, d_ack, if_err, d_err}, 32'd0);
    chk("rst_rdata", {if_rdata, d_rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    issue(1, 16'h0000, 0, 0, 16'h0, 16'h0);          // fetch word 0 -> 16'h1201
    issue(0, 16'h0, 1, 1, 16'h0066, 16'h0003);       // store
    issue(0, 16'h0, 1, 0, 16'h0066, 16'h0);          // load back
    issue(0, 16'h0, 1, 0, 16'h0003, 16'h0);          // odd address
    issue(0, 16'h0, 1, 0, 16'h0080, 16'h0);          // one past the end
    issue(0, 16'h0, 1, 0, 16'h007E, 16'h0);          // last legal word
    issue(1, 16'h0081, 0, 0, 16'h0, 16'h0);          // illegal fetch

    // Reset in the middle of the write strobe.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
    for (int w = 0; w < 10 && mem_r_nWb; w++) @(negedge clk);
    chk("strobe_reached", {31'd0, mem_r_nWb}, 32'd0);
    #1 rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    chk("async_rst_r_nWb", {31'd0, mem_r_nWb}, 32'd1);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
    rst_n = 1'b1;
    last_is_d = 1'b0;
    ram[16] = ref_mem[16]; ram[17] = ref_mem[17];  // a cut-short store may or may not land
    issue(1, 16'h0002, 0, 0, 16'h0, 16'h0);

    // Three ties in a row.
    issue(1, 16'h0004, 1, 0, 16'h0008, 16'h0);
    issue(1, 16'h000A, 1, 1, 16'h000C, 16'h5A5A);
    issue(1, 16'h000C, 1, 0, 16'h0066, 16'h0);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      int          mode;
      logic [15:0] ia, da;
      mode = int'($urandom_range(0, 2));
      ia = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63) * 2);
      da = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 63) * 2);
      issue(mode != 1, ia, mode != 0, 1'($urandom), da, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

endmodule
